// File: rtl/data_cache_pkg.sv
// Shared definitions for the direct-mapped write-back data cache.
package data_cache_pkg;

    localparam int unsigned WORD_W  = 32;
    localparam int unsigned ADDR_W  = 30;
    localparam int unsigned TAG_W   = 25;
    localparam int unsigned IDX_W   = 3;
    localparam int unsigned OFF_W   = 2;
    localparam int unsigned LINE_W  = 128;
    localparam int unsigned MADDR_W = TAG_W + IDX_W;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        ALLOCATE  = 2'd2
    } cache_state_e;

    // Select one 32-bit word of a line; word 0 sits in the low bits.
    function automatic logic [WORD_W-1:0] line_word(input logic [LINE_W-1:0] line,
                                                    input logic [OFF_W-1:0]  off);
        return line[{off, 5'd0} +: WORD_W];
    endfunction

endpackage

// File: rtl/data_cache_array.sv
// Tag, data, valid and dirty storage with a whole-line refill port and a single-word store port.
module dcache_array
    import data_cache_pkg::*;
#(
    parameter int unsigned NUM_BLOCKS      = 8,
    parameter int unsigned WORDS_PER_BLOCK = 4
) (
    input  logic               clk,
    input  logic               rst_i,
    input  logic [IDX_W-1:0]   idx_i,
    output logic [TAG_W-1:0]   tag_o,
    output logic [LINE_W-1:0]  line_o,
    output logic               valid_o,
    output logic               dirty_o,
    input  logic               line_we_i,
    input  logic [TAG_W-1:0]   tag_i,
    input  logic [LINE_W-1:0]  line_i,
    input  logic               word_we_i,
    input  logic [OFF_W-1:0]   off_i,
    input  logic [WORD_W-1:0]  word_i,
    input  logic               dirty_clr_i
);

    logic [NUM_BLOCKS-1:0] valid_q;
    logic [NUM_BLOCKS-1:0] dirty_q;
    logic [TAG_W-1:0]      tag_q  [NUM_BLOCKS];
    logic [WORDS_PER_BLOCK-1:0][WORD_W-1:0] data_q [NUM_BLOCKS];

    // Combinational read of the addressed line.
    assign tag_o   = tag_q[idx_i];
    assign line_o  = data_q[idx_i];
    assign valid_o = valid_q[idx_i];
    assign dirty_o = dirty_q[idx_i];

    // Status bits: cleared by reset, set on refill (valid) and store (dirty).
    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            if (line_we_i) begin
                valid_q[idx_i] <= 1'b1;
                dirty_q[idx_i] <= 1'b0;
            end
            if (dirty_clr_i) begin
                dirty_q[idx_i] <= 1'b0;
            end
            if (word_we_i) begin
                dirty_q[idx_i] <= 1'b1;
            end
        end
    end

    // Tag and data payload: no reset, meaningless while the line is invalid.
    always_ff @(posedge clk) begin
        if (line_we_i) begin
            tag_q[idx_i]  <= tag_i;
            data_q[idx_i] <= line_i;
        end else if (word_we_i) begin
            data_q[idx_i][off_i] <= word_i;
        end
    end

endmodule

// File: rtl/data_cache.sv
// Direct-mapped, write-back, write-allocate data cache with a line-wide memory port.
module data_cache
    import data_cache_pkg::*;
#(
    parameter int unsigned NUM_BLOCKS      = 8,
    parameter int unsigned WORDS_PER_BLOCK = 4
) (
    input  logic                clk,
    input  logic                proc_reset,
    input  logic                proc_read,
    input  logic                proc_write,
    input  logic [ADDR_W-1:0]   proc_addr,
    input  logic [WORD_W-1:0]   proc_wdata,
    output logic                proc_stall,
    output logic [WORD_W-1:0]   proc_rdata,
    output logic                mem_read,
    output logic                mem_write,
    output logic [MADDR_W-1:0]  mem_addr,
    output logic [LINE_W-1:0]   mem_wdata,
    input  logic                mem_ready,
    input  logic [LINE_W-1:0]   mem_rdata
);

    logic [TAG_W-1:0]  req_tag;
    logic [IDX_W-1:0]  req_idx;
    logic [OFF_W-1:0]  req_off;

    logic [TAG_W-1:0]  arr_tag;
    logic [LINE_W-1:0] arr_line;
    logic              arr_valid;
    logic              arr_dirty;

    logic              req_c;
    logic              hit_c;
    logic              word_we_c;
    logic              line_we_c;
    logic              dirty_clr_c;

    cache_state_e      state_q;

    // Split the word address into tag / index / word offset.
    assign req_tag = proc_addr[ADDR_W-1 -: TAG_W];
    assign req_idx = proc_addr[OFF_W +: IDX_W];
    assign req_off = proc_addr[OFF_W-1:0];

    assign req_c = proc_read | proc_write;
    assign hit_c = arr_valid && (arr_tag == req_tag);

    // Array update strobes: stores only complete as hits in IDLE; refill and writeback finish on mem_ready.
    assign word_we_c   = (state_q == IDLE) && proc_write && hit_c;
    assign line_we_c   = (state_q == ALLOCATE) && mem_ready;
    assign dirty_clr_c = (state_q == WRITEBACK) && mem_ready;

    dcache_array #(
        .NUM_BLOCKS      (NUM_BLOCKS),
        .WORDS_PER_BLOCK (WORDS_PER_BLOCK)
    ) u_array (
        .clk         (clk),
        .rst_i       (proc_reset),
        .idx_i       (req_idx),
        .tag_o       (arr_tag),
        .line_o      (arr_line),
        .valid_o     (arr_valid),
        .dirty_o     (arr_dirty),
        .line_we_i   (line_we_c),
        .tag_i       (req_tag),
        .line_i      (mem_rdata),
        .word_we_i   (word_we_c),
        .off_i       (req_off),
        .word_i      (proc_wdata),
        .dirty_clr_i (dirty_clr_c)
    );

    // Miss handling: evict a dirty victim first, then refill, then let the held request hit.
    always_ff @(posedge clk or posedge proc_reset) begin
        if (proc_reset) begin
            state_q <= IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_c && !hit_c) begin
                        state_q <= (arr_valid && arr_dirty) ? WRITEBACK : ALLOCATE;
                    end
                end
                WRITEBACK: begin
                    if (mem_ready) begin
                        state_q <= ALLOCATE;
                    end
                end
                ALLOCATE: begin
                    if (mem_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Processor side: zero-wait hits, stall for the whole miss sequence.
    assign proc_stall = (state_q != IDLE) || (req_c && !hit_c);
    assign proc_rdata = line_word(arr_line, req_off);

    // Memory side: strobes decoded from state; address and data come from held request and victim line.
    assign mem_write = (state_q == WRITEBACK);
    assign mem_read  = (state_q == ALLOCATE);
    assign mem_addr  = mem_write ? {arr_tag, req_idx} : {req_tag, req_idx};
    assign mem_wdata = arr_line;

endmodule

// File: tb/tb_data_cache.sv
// Scoreboard bench for data_cache: directed scenarios followed by random traffic.
module tb_data_cache;
    import data_cache_pkg::*;

    logic                clk = 1'b0;
    logic                proc_reset;
    logic                proc_read;
    logic                proc_write;
    logic [ADDR_W-1:0]   proc_addr;
    logic [WORD_W-1:0]   proc_wdata;
    logic                proc_stall;
    logic [WORD_W-1:0]   proc_rdata;
    logic                mem_read;
    logic                mem_write;
    logic [MADDR_W-1:0]  mem_addr;
    logic [LINE_W-1:0]   mem_wdata;
    logic                mem_ready;
    logic [LINE_W-1:0]   mem_rdata;

    always #5 clk = ~clk;

    data_cache #(.NUM_BLOCKS(8), .WORDS_PER_BLOCK(4)) dut (
        .clk        (clk),
        .proc_reset (proc_reset),
        .proc_read  (proc_read),
        .proc_write (proc_write),
        .proc_addr  (proc_addr),
        .proc_wdata (proc_wdata),
        .proc_stall (proc_stall),
        .proc_rdata (proc_rdata),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ready  (mem_ready),
        .mem_rdata  (mem_rdata)
    );

    typedef struct { bit is_wr; logic [27:0] addr; logic [127:0] data; } mem_exp_t;
    typedef struct { int stall; bit chk_data; logic [31:0] data; } rsp_exp_t;

    mem_exp_t exp_mem_q[$];
    rsp_exp_t exp_rsp_q[$];
    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: cache contents and the memory image as the cache should see it.
    bit           r_valid [8];
    bit           r_dirty [8];
    logic [24:0]  r_tag   [8];
    logic [31:0]  r_word  [8][4];
    logic [127:0] ref_mem [logic [27:0]];
    // Memory image held by the bench's memory responder.
    logic [127:0] env_mem [logic [27:0]];

    int lat_wb_cur = 1;
    int lat_al_cur = 1;
    bit resp_en    = 1'b1;
    bit inj_ready  = 1'b0;
    bit abort_run  = 1'b0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [127:0] init_line(input logic [27:0] a);
        logic [127:0] l;
        for (int w = 0; w < 4; w++) begin
            l[w*32 +: 32] = (32'(a) * 32'h9E37_79B9) ^ (32'h1111_1111 * 32'(w + 1));
        end
        return l;
    endfunction

    function automatic logic [127:0] env_load(input logic [27:0] a);
        if (env_mem.exists(a)) return env_mem[a];
        return init_line(a);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            r_valid[i] = 1'b0;
            r_dirty[i] = 1'b0;
        end
    endtask

    // Predict memory traffic, stall length and load data of one request.
    task automatic model_op(input bit rd, input bit wr, input logic [29:0] addr,
                            input logic [31:0] wd, input int lwb, input int lal);
        int           idx;
        int           off;
        logic [24:0]  tag;
        bit           hit;
        bit           wb;
        logic [127:0] line;
        mem_exp_t     m;
        rsp_exp_t     r;
        idx = int'(addr[4:2]);
        off = int'(addr[1:0]);
        tag = addr[29:5];
        hit = r_valid[idx] && (r_tag[idx] == tag);
        wb  = 1'b0;
        if (!hit) begin
            if (r_valid[idx] && r_dirty[idx]) begin
                wb = 1'b1;
                for (int w = 0; w < 4; w++) line[w*32 +: 32] = r_word[idx][w];
                m.is_wr = 1'b1;
                m.addr  = {r_tag[idx], addr[4:2]};
                m.data  = line;
                exp_mem_q.push_back(m);
                ref_mem[m.addr] = line;
            end
            m.is_wr = 1'b0;
            m.addr  = addr[29:2];
            m.data  = '0;
            exp_mem_q.push_back(m);
            line = ref_mem.exists(m.addr) ? ref_mem[m.addr] : init_line(m.addr);
            for (int w = 0; w < 4; w++) r_word[idx][w] = line[w*32 +: 32];
            r_valid[idx] = 1'b1;
            r_dirty[idx] = 1'b0;
            r_tag[idx]   = tag;
        end
        r.stall    = hit ? 0 : (1 + lal + (wb ? lwb : 0));
        r.chk_data = rd && !wr;
        r.data     = r_word[idx][off];
        if (wr) begin
            r_word[idx][off] = wd;
            r_dirty[idx]     = 1'b1;
        end
        exp_rsp_q.push_back(r);
    endtask

    // Issue one request and hold it until the cache stops stalling.
    task automatic do_op(input bit rd, input bit wr, input logic [29:0] a,
                         input logic [31:0] d, input int lwb, input int lal);
        bit ok;
        model_op(rd, wr, a, d, lwb, lal);
        lat_wb_cur = lwb;
        lat_al_cur = lal;
        proc_read  = rd;
        proc_write = wr;
        proc_addr  = a;
        proc_wdata = d;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!proc_stall) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_cmp++;
            n_bad++;
            $display("FAIL op_timeout: addr %h still stalled after 100 cycles", a);
            abort_run = 1'b1;
        end
        @(posedge clk);
        #1;
        proc_read  = 1'b0;
        proc_write = 1'b0;
    endtask

    // Memory responder: raises mem_ready after the chosen number of request cycles.
    initial begin : responder
        int cnt;
        bit was;
        int lat;
        cnt       = 0;
        mem_ready = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            was       = mem_ready;
            mem_ready = 1'b0;
            if (inj_ready) begin
                mem_ready = 1'b1;
                mem_rdata = {4{$urandom}};
                cnt       = 0;
            end else if (resp_en && (mem_read || mem_write)) begin
                if (was) cnt = 0;
                cnt++;
                lat = mem_write ? lat_wb_cur : lat_al_cur;
                if (cnt >= lat) begin
                    mem_ready = 1'b1;
                    if (mem_write) env_mem[mem_addr] = mem_wdata;
                    else           mem_rdata = env_load(mem_addr);
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // Monitor: pops expectations whenever the cache completes a memory transfer or a request.
    initial begin : monitor
        int       stall_cnt;
        mem_exp_t m;
        rsp_exp_t r;
        stall_cnt = 0;
        forever begin
            @(negedge clk);
            if (proc_reset) begin
                stall_cnt = 0;
                continue;
            end
            if (mem_read || mem_write) chk("mem_exclusive", 128'(mem_read && mem_write), 128'(0));
            if (mem_ready && (mem_read || mem_write)) begin
                if (exp_mem_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL mem_unexpected: rd=%0b wr=%0b addr %h, none expected", mem_read, mem_write, mem_addr);
                end else begin
                    m = exp_mem_q.pop_front();
                    chk("mem_is_write", 128'(mem_write), 128'(m.is_wr));
                    chk("mem_addr", 128'(mem_addr), 128'(m.addr));
                    if (m.is_wr) chk("mem_wdata", mem_wdata, m.data);
                end
            end
            if (proc_read || proc_write) begin
                if (proc_stall) begin
                    stall_cnt++;
                end else begin
                    if (exp_rsp_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL rsp_unexpected: completion at addr %h, none expected", proc_addr);
                    end else begin
                        r = exp_rsp_q.pop_front();
                        chk("stall_cycles", 128'(stall_cnt), 128'(r.stall));
                        if (r.chk_data) chk("rdata", 128'(proc_rdata), 128'(r.data));
                    end
                    stall_cnt = 0;
                end
            end else begin
                stall_cnt = 0;
                chk("idle_stall", 128'(proc_stall), 128'(0));
                chk("idle_mem", 128'({mem_read, mem_write}), 128'(0));
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // Stimulus: directed scenarios, a mid-refill reset, then random traffic.
    initial begin : stimulus
        logic [29:0] ra;
        int          kind;
        bit          seen;
        proc_reset = 1'b1;
        proc_read  = 1'b0;
        proc_write = 1'b0;
        proc_addr  = '0;
        proc_wdata = '0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_mem_read", 128'(mem_read), 128'(0));
        chk("reset_mem_write", 128'(mem_write), 128'(0));
        @(posedge clk);
        #1;
        proc_reset = 1'b0;
        @(posedge clk);
        #1;

        do_op(1'b1, 1'b0, 30'h4,   32'h0,         1, 3);   // clean read miss
        do_op(1'b0, 1'b1, 30'h4,   32'h1234_5678, 1, 1);   // write hit
        do_op(1'b1, 1'b0, 30'h4,   32'h0,         1, 1);   // read hit returns store
        do_op(1'b1, 1'b0, 30'h104, 32'h0,         2, 2);   // dirty eviction
        do_op(1'b0, 1'b1, 30'h20,  32'hCAFE_F00D, 1, 2);   // write miss allocates
        do_op(1'b1, 1'b1, 30'h21,  32'hA5A5_5A5A, 1, 1);   // read+write hit: store wins
        do_op(1'b1, 1'b0, 30'h21,  32'h0,         1, 1);
        do_op(1'b1, 1'b0, 30'h420, 32'h0,         3, 1);   // evicts the line holding both stores

        // Reset while refilling, then a late mem_ready.
        ra         = {25'd100, 3'd7, 2'd1};
        resp_en    = 1'b0;
        proc_addr  = ra;
        proc_read  = 1'b1;
        seen       = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (mem_read) begin
                seen = 1'b1;
                break;
            end
        end
        chk("rst_test_alloc_seen", 128'(seen), 128'(1));
        @(posedge clk);
        #1;
        proc_reset = 1'b1;
        proc_read  = 1'b0;
        @(negedge clk);
        chk("rst_mid_mem_read", 128'(mem_read), 128'(0));
        chk("rst_mid_mem_write", 128'(mem_write), 128'(0));
        @(posedge clk);
        #1;
        proc_reset = 1'b0;
        model_reset();
        @(negedge clk);
        inj_ready = 1'b1;
        @(negedge clk);
        inj_ready = 1'b0;
        @(negedge clk);
        chk("late_ready_mem_read", 128'(mem_read), 128'(0));
        chk("late_ready_mem_write", 128'(mem_write), 128'(0));
        resp_en = 1'b1;
        @(posedge clk);
        #1;
        do_op(1'b1, 1'b0, ra, 32'h0, 1, 2);                // misses again after reset

        for (int n = 0; n < 250 && !abort_run; n++) begin
            ra   = {25'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
            kind = int'($urandom_range(0, 9));
            do_op(kind < 5 || kind == 9, kind >= 5, ra, $urandom,
                  int'($urandom_range(1, 4)), int'($urandom_range(1, 4)));
            if ($urandom_range(0, 2) == 0) begin
                @(posedge clk);
                #1;
            end
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("leftover_mem_exp", 128'(exp_mem_q.size()), 128'(0));
        chk("leftover_rsp_exp", 128'(exp_rsp_q.size()), 128'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
